fetch_unit: RTL

Instruction fetch stage of the 16-bit RISC pipeline, directly upstream of the decode stage. Holds the fetch PC, issues word reads to instruction memory through a request/grant handshake, and buffers returned instructions in a small in-order queue. Decode drains the queue with a valid/ready handshake. A redirect from the branch logic flushes the queue and drops any in-flight memory responses.

---
 rtl/fetch_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the 16-bit RISC pipeline.
//
// Holds the fetch PC and issues one-word reads to instruction memory over a
// request/grant handshake. Returned words are tagged with their own address
// and buffered in a small in-order queue that decode drains with valid/ready.
// A redirect flushes the queue, restarts fetch at the new PC and discards
// every response still in flight.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   imem_req/addr      read request and word address (addr = fetch PC)
//   imem_gnt           request accepted this cycle
//   imem_rvalid/rdata  in-order read response
//   redirect_valid/pc  taken branch/jump: restart fetch at redirect_pc
//   if_valid           queue head valid toward decode
//   if_instruction     queue head instruction
//   if_pc/if_pc_plus1  address of the head instruction and that address + 1
//   id_ready           decode accepts the head this cycle
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        if_valid,
  output logic [15:0] if_instruction,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus1,
  input  logic        id_ready
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  localparam logic [CNT_W:0]   DEPTH_C    = (CNT_W + 1)'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] FULL_C     = CNT_W'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(QUEUE_DEPTH - 1);
  // Largest number of reads (live + stale) the counters can represent.
  localparam logic [CNT_W:0]   FLIGHT_MAX = (CNT_W + 1)'((1 << CNT_W) - 1);

  // Circular pointer increment that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic [15:0]      fetch_pc;

  // Instruction queue: {instr, pc} entries, head is what decode sees.
  logic [15:0]      q_instr [QUEUE_DEPTH];
  logic [15:0]      q_pc    [QUEUE_DEPTH];
  logic [PTR_W-1:0] q_head;
  logic [PTR_W-1:0] q_tail;
  logic [CNT_W-1:0] count;

  // Per-request PC tags, one per live (non-stale) read in flight.
  logic [15:0]      tag_pc  [QUEUE_DEPTH];
  logic [PTR_W-1:0] tag_head;
  logic [PTR_W-1:0] tag_tail;

  // outstanding: live reads in flight (their data will be queued).
  // drop:        stale reads in flight (their data will be discarded).
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop;

  logic [CNT_W:0]   credit_used;
  logic [CNT_W:0]   in_flight;
  logic             grant;
  logic             push;
  logic             pop;

  always_comb begin
    credit_used = {1'b0, count} + {1'b0, outstanding};
    in_flight   = {1'b0, outstanding} + {1'b0, drop};
    // Credit covers queue slots only; the in_flight bound keeps drop from
    // wrapping when redirects arrive back to back against a slow memory.
    imem_req    = !redirect_valid && (credit_used < DEPTH_C) && (in_flight < FLIGHT_MAX);
    imem_addr   = fetch_pc;
    grant       = imem_req && imem_gnt;
    // Stale data drains first because memory answers in request order.
    push        = imem_rvalid && (drop == '0) && !redirect_valid;
    pop         = if_valid && id_ready;
  end

  // ---- request / credit control ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      q_head      <= '0;
      q_tail      <= '0;
      count       <= '0;
      tag_head    <= '0;
      tag_tail    <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc;
      // Empty the queue without moving the head, so the output holds.
      count       <= '0;
      q_tail      <= q_head;
      tag_tail    <= tag_head;
      // Every live read becomes stale; a response this cycle retires one
      // of them (stale or live, the total in flight drops by one).
      outstanding <= '0;
      drop        <= drop + outstanding - CNT_W'(imem_rvalid);
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + 16'd1;
        tag_tail <= ptr_inc(tag_tail);
      end
      if (push) begin
        tag_head <= ptr_inc(tag_head);
        q_tail   <= ptr_inc(q_tail);
      end
      if (pop) begin
        q_head <= ptr_inc(q_head);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({grant, push})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (imem_rvalid && (drop != '0)) begin
        drop <= drop - 1'b1;
      end
    end
  end

  // ---- request tag capture ----
  always_ff @(posedge clk) begin
    if (grant) begin
      tag_pc[tag_tail] <= fetch_pc;
    end
  end

  // ---- response capture into the queue ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (push) begin
      q_instr[q_tail] <= imem_rdata;
      q_pc[q_tail]    <= tag_pc[tag_head];
    end
  end

  // ---- queue head toward decode ----
  always_comb begin
    if_valid       = (count != '0);
    if_instruction = q_instr[q_head];
    if_pc          = q_pc[q_head];
    if_pc_plus1    = q_pc[q_head] + 16'd1;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_rvalid && (outstanding == '0) && (drop == '0)));
      assert (!(push && (count == FULL_C)));
    end
  end

endmodule
